// File: rtl/pcm_mixer_player.sv
// rtl/pcm_mixer_player.sv - multi-voice 8-bit unsigned PCM player with shared byte fetch, volume, mix and saturation
module pcm_mixer_player #(
   parameter int NCH     = 4,
   parameter int ADDR_W  = 28,
   parameter int LEN_W   = 24,
   parameter int CLK_DIV = 3000
) (
   input  logic                    clk_sys,
   input  logic                    reset,
   input  logic [NCH*ADDR_W-1:0]   ch_start,
   input  logic [NCH*LEN_W-1:0]    ch_len,
   input  logic [NCH*4-1:0]        ch_vol,
   input  logic [NCH-1:0]          ch_loop,
   input  logic [NCH-1:0]          ch_trig,
   input  logic [NCH-1:0]          ch_stop,
   input  logic                    pause,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic                    mem_rd,
   input  logic [7:0]              mem_data,
   input  logic                    mem_ready,
   output logic [15:0]             audio_out,
   output logic [NCH-1:0]          ch_busy,
   output logic                    overrun
);

   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int SW = 20;

   typedef enum logic [2:0] {S_IDLE, S_SEL, S_REQ, S_WAIT, S_MIX} state_t;

   state_t              state_q;
   logic [PW-1:0]       presc_q;
   logic [NCH-1:0]      active_q;
   logic [NCH-1:0]      done_q;
   logic [NCH-1:0]      pend_q;
   logic [ADDR_W-1:0]   pos_q  [NCH];
   logic [LEN_W-1:0]    rem_q  [NCH];
   logic [7:0]          samp_q [NCH];
   logic [IW-1:0]       cur_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic                mem_rd_q;
   logic [15:0]         audio_q;
   logic                overrun_q;

   logic                tick_d;
   logic                fetch_d;
   logic                sel_found_d;
   logic [IW-1:0]       sel_idx_d;
   logic signed [SW-1:0]   term_d;
   logic signed [SW-1:0]   sum_d;
   logic signed [SW+3:0]   shift_d;
   logic [15:0]         audio_d;

   assign tick_d  = !pause && (presc_q == PW'(CLK_DIV - 1));
   assign fetch_d = (state_q == S_WAIT) && mem_ready;

   // lowest-index voice still pending and not stopped since the snapshot
   always_comb begin
      sel_found_d = 1'b0;
      sel_idx_d   = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (pend_q[i] && active_q[i]) begin
            sel_found_d = 1'b1;
            sel_idx_d   = IW'(i);
         end
      end
   end

   always_comb begin
      term_d = '0;
      sum_d  = '0;
      for (int i = 0; i < NCH; i++) begin
         term_d = (SW'($signed({1'b0, samp_q[i]})) - SW'(128))
                * SW'($signed({1'b0, ch_vol[i*4 +: 4]}));
         sum_d  = sum_d + term_d;
      end
      shift_d = {sum_d, 4'b0000};
      if (shift_d > 24'sd32767)
         audio_d = 16'h7FFF;
      else if (shift_d < -24'sd32768)
         audio_d = 16'h8000;
      else
         audio_d = shift_d[15:0];
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q    <= S_IDLE;
         presc_q    <= '0;
         active_q   <= '0;
         done_q     <= '0;
         pend_q     <= '0;
         cur_q      <= '0;
         mem_addr_q <= '0;
         mem_rd_q   <= 1'b0;
         audio_q    <= '0;
         overrun_q  <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            pos_q[i]  <= '0;
            rem_q[i]  <= '0;
            samp_q[i] <= 8'h80;
         end
      end else begin
         if (!pause)
            presc_q <= tick_d ? '0 : presc_q + PW'(1);
         if (tick_d && state_q != S_IDLE)
            overrun_q <= 1'b1;

         case (state_q)
            S_IDLE: if (tick_d) begin
               pend_q  <= active_q;
               state_q <= S_SEL;
            end
            S_SEL: if (!pause) begin
               if (sel_found_d) begin
                  cur_q      <= sel_idx_d;
                  mem_addr_q <= pos_q[sel_idx_d];
                  mem_rd_q   <= 1'b1;
                  state_q    <= S_REQ;
               end else begin
                  state_q <= S_MIX;
               end
            end
            S_REQ: begin
               mem_rd_q <= 1'b0;
               state_q  <= S_WAIT;
            end
            S_WAIT: if (mem_ready) begin
               pend_q[cur_q] <= 1'b0;
               state_q       <= S_SEL;
            end
            S_MIX: if (!pause) begin
               audio_q <= audio_d;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase

         // later assignments win: fetch update < trigger < stop
         for (int i = 0; i < NCH; i++) begin
            if (tick_d && state_q == S_IDLE && done_q[i]) begin
               samp_q[i] <= 8'h80;
               done_q[i] <= 1'b0;
            end
            if (fetch_d && cur_q == IW'(i)) begin
               samp_q[i] <= mem_data;
               pos_q[i]  <= pos_q[i] + ADDR_W'(1);
               rem_q[i]  <= rem_q[i] - LEN_W'(1);
               if (rem_q[i] == LEN_W'(1)) begin
                  if (ch_loop[i] && ch_len[i*LEN_W +: LEN_W] != '0) begin
                     pos_q[i] <= ch_start[i*ADDR_W +: ADDR_W];
                     rem_q[i] <= ch_len[i*LEN_W +: LEN_W];
                  end else begin
                     active_q[i] <= 1'b0;
                     done_q[i]   <= 1'b1;
                  end
               end
            end
            if (ch_trig[i] && ch_len[i*LEN_W +: LEN_W] != '0) begin
               pos_q[i]    <= ch_start[i*ADDR_W +: ADDR_W];
               rem_q[i]    <= ch_len[i*LEN_W +: LEN_W];
               active_q[i] <= 1'b1;
               done_q[i]   <= 1'b0;
            end
            if (ch_stop[i]) begin
               active_q[i] <= 1'b0;
               samp_q[i]   <= 8'h80;
               done_q[i]   <= 1'b0;
            end
         end
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_rd    = mem_rd_q;
   assign audio_out = audio_q;
   assign ch_busy   = active_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_pcm_mixer_player.sv
// tb/tb_pcm_mixer_player.sv - directed self-checking bench for pcm_mixer_player
module tb_pcm_mixer_player;
   localparam int NCH = 4, AW = 28, LW = 24, DIV = 20;
   localparam logic [15:0] SEQ [4] = '{16'h0000, 16'h7710, 16'h8800, 16'h0F00};

   logic              clk_sys = 1'b0;
   logic              reset   = 1'b1;
   logic [NCH*AW-1:0] ch_start = '0;
   logic [NCH*LW-1:0] ch_len   = '0;
   logic [NCH*4-1:0]  ch_vol   = '0;
   logic [NCH-1:0]    ch_loop  = '0;
   logic [NCH-1:0]    ch_trig  = '0;
   logic [NCH-1:0]    ch_stop  = '0;
   logic              pause    = 1'b0;
   logic [AW-1:0]     mem_addr;
   logic              mem_rd;
   logic [7:0]        mem_data  = '0;
   logic              mem_ready = 1'b0;
   logic [15:0]       audio_out;
   logic [NCH-1:0]    ch_busy;
   logic              overrun;

   int          checks = 0, failures = 0;
   int          rd_cnt = 0, rd0, lat = 1, wait_cnt = 0, ph = 0;
   logic [AW-1:0] last_rd = '0;
   logic [9:0]  addr_l = '0;
   logic [7:0]  mem [1024];

   pcm_mixer_player #(.NCH(NCH), .ADDR_W(AW), .LEN_W(LW), .CLK_DIV(DIV)) dut (
      .clk_sys(clk_sys), .reset(reset), .ch_start(ch_start), .ch_len(ch_len),
      .ch_vol(ch_vol), .ch_loop(ch_loop), .ch_trig(ch_trig), .ch_stop(ch_stop),
      .pause(pause), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
      .mem_ready(mem_ready), .audio_out(audio_out), .ch_busy(ch_busy), .overrun(overrun));

   always #5 clk_sys = ~clk_sys;

   // independent prescaler phase model used only to find tick edges
   always @(posedge clk_sys) begin
      if (reset) ph <= 0;
      else if (!pause) ph <= (ph == DIV - 1) ? 0 : ph + 1;
   end

   // byte memory: data strobe arrives lat+1 edges after the request edge
   always @(posedge clk_sys) begin
      #1;
      mem_ready = 1'b0;
      if (wait_cnt > 0) begin
         wait_cnt = wait_cnt - 1;
         if (wait_cnt == 0) begin
            mem_ready = 1'b1;
            mem_data  = mem[addr_l];
         end
      end
      if (mem_rd) begin
         addr_l   = mem_addr[9:0];
         last_rd  = mem_addr;
         rd_cnt   = rd_cnt + 1;
         wait_cnt = lat;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic set_voice(input int v, input logic [AW-1:0] s, input logic [LW-1:0] l,
                            input logic [3:0] vol, input logic lp);
      ch_start[v*AW +: AW] = s;
      ch_len[v*LW +: LW]   = l;
      ch_vol[v*4 +: 4]     = vol;
      ch_loop[v]           = lp;
   endtask

   task automatic pulse(input logic [NCH-1:0] t, input logic [NCH-1:0] s);
      ch_trig = t;
      ch_stop = s;
      @(negedge clk_sys);
      ch_trig = '0;
      ch_stop = '0;
   endtask

   task automatic wait_tick_edge();
      int guard = 0;
      @(negedge clk_sys);
      while (!(ph == DIV - 1 && !pause) && guard < 100) begin
         @(negedge clk_sys);
         guard++;
      end
      if (guard >= 100) check_val("tick_timeout", 32'(guard), 32'd0);
      @(posedge clk_sys);
   endtask

   task automatic tick_sample();
      wait_tick_edge();
      repeat (16) @(negedge clk_sys);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'h80;
      mem[10'h100] = 8'h80; mem[10'h101] = 8'hFF; mem[10'h102] = 8'h00; mem[10'h103] = 8'h90;
      mem[10'h200] = 8'hFF; mem[10'h201] = 8'h00; mem[10'h202] = 8'hC0;

      repeat (3) @(negedge clk_sys);
      check_val("rst_audio", 32'(audio_out), 32'h0);
      check_val("rst_busy", 32'(ch_busy), 32'h0);
      check_val("rst_rd", 32'(mem_rd), 32'h0);
      check_val("rst_ovr", 32'(overrun), 32'h0);
      check_val("rst_addr", 32'(mem_addr), 32'h0);
      reset = 1'b0;

      // single voice, one-shot
      tick_sample();
      set_voice(0, 28'h100, 24'd4, 4'd15, 1'b0);
      rd0 = rd_cnt;
      pulse(4'b0001, 4'b0000);
      for (int k = 0; k < 4; k++) begin
         tick_sample();
         check_val($sformatf("s1_audio%0d", k), 32'(audio_out), 32'(SEQ[k]));
         check_val($sformatf("s1_rdaddr%0d", k), 32'(last_rd), 32'h100 + 32'(k));
         check_val($sformatf("s1_rdcnt%0d", k), 32'(rd_cnt - rd0), 32'(k + 1));
      end
      check_val("s1_busy_end", 32'(ch_busy), 32'h0);
      tick_sample();
      check_val("s1_audio_idle", 32'(audio_out), 32'h0);
      check_val("s1_no_rd", 32'(rd_cnt - rd0), 32'd4);
      check_val("s1_addr_hold", 32'(mem_addr), 32'h103);

      // single voice, looping
      ch_loop[0] = 1'b1;
      pulse(4'b0001, 4'b0000);
      for (int k = 0; k < 12; k++) begin
         tick_sample();
         check_val($sformatf("s2_audio%0d", k), 32'(audio_out), 32'(SEQ[k % 4]));
         check_val($sformatf("s2_rdaddr%0d", k), 32'(last_rd), 32'h100 + 32'(k % 4));
         check_val($sformatf("s2_busy%0d", k), 32'(ch_busy), 32'h1);
      end
      pulse(4'b0000, 4'b0001);
      tick_sample();
      check_val("s2_stopped", 32'(audio_out), 32'h0);

      // four voices: saturation both ways, then an unsaturated mix
      for (int v = 0; v < 4; v++) set_voice(v, 28'h200, 24'd1, 4'd15, 1'b1);
      pulse(4'b1111, 4'b0000);
      tick_sample();
      check_val("s3_sat_pos", 32'(audio_out), 32'h7FFF);
      for (int v = 0; v < 4; v++) set_voice(v, 28'h201, 24'd1, 4'd15, 1'b1);
      pulse(4'b1111, 4'b0000);
      tick_sample();
      check_val("s3_sat_neg", 32'(audio_out), 32'h8000);
      for (int v = 0; v < 4; v++) set_voice(v, 28'h202, 24'd1, 4'(v + 3), 1'b1);
      pulse(4'b1111, 4'b0000);
      tick_sample();
      check_val("s3_mix", 32'(audio_out), 32'h4800);
      check_val("s3_busy", 32'(ch_busy), 32'hF);
      pulse(4'b0000, 4'b1111);
      tick_sample();
      check_val("s3_all_stop", 32'(audio_out), 32'h0);

      // stop beats trigger, zero-length trigger ignored, pause freezes
      set_voice(2, 28'h202, 24'd1, 4'd3, 1'b1);
      pulse(4'b0100, 4'b0000);
      tick_sample();
      check_val("s4_audio", 32'(audio_out), 32'h0C00);
      check_val("s4_busy", 32'(ch_busy), 32'h4);
      pulse(4'b0100, 4'b0100);
      check_val("s4_stop_wins", 32'(ch_busy), 32'h0);
      ch_len[2*LW +: LW] = '0;
      pulse(4'b0100, 4'b0000);
      check_val("s4_len0", 32'(ch_busy), 32'h0);
      ch_len[2*LW +: LW] = 24'd1;
      pulse(4'b0100, 4'b0000);
      tick_sample();
      check_val("s4_retrig", 32'(audio_out), 32'h0C00);
      rd0   = rd_cnt;
      pause = 1'b1;
      repeat (5 * DIV) @(negedge clk_sys);
      check_val("s4_pause_rd", 32'(rd_cnt - rd0), 32'd0);
      check_val("s4_pause_audio", 32'(audio_out), 32'h0C00);
      check_val("s4_pause_busy", 32'(ch_busy), 32'h4);
      pause = 1'b0;
      tick_sample();
      check_val("s4_resume_rd", 32'(rd_cnt - rd0), 32'd1);
      pulse(4'b0000, 4'b0100);

      // slow memory with two voices: overrun, no duplicate requests
      tick_sample();
      check_val("s5_pre_audio", 32'(audio_out), 32'h0);
      set_voice(0, 28'h200, 24'd1, 4'd1, 1'b1);
      set_voice(1, 28'h202, 24'd1, 4'd1, 1'b1);
      lat = 30;
      check_val("s5_pre_ovr", 32'(overrun), 32'h0);
      pulse(4'b0011, 4'b0000);
      rd0 = rd_cnt;
      wait_tick_edge();
      repeat (70) @(negedge clk_sys);
      check_val("s5_ovr", 32'(overrun), 32'h1);
      check_val("s5_rdcnt", 32'(rd_cnt - rd0), 32'd2);
      check_val("s5_audio", 32'(audio_out), 32'h0BF0);

      // reset while a fetch is outstanding
      lat = 10;
      wait_tick_edge();
      repeat (4) @(negedge clk_sys);
      reset = 1'b1;
      @(negedge clk_sys);
      check_val("s6_rd", 32'(mem_rd), 32'h0);
      check_val("s6_audio", 32'(audio_out), 32'h0);
      check_val("s6_busy", 32'(ch_busy), 32'h0);
      check_val("s6_ovr", 32'(overrun), 32'h0);
      reset = 1'b0;
      rd0   = rd_cnt;
      repeat (3 * DIV) @(negedge clk_sys);
      check_val("s6_late_rd", 32'(rd_cnt - rd0), 32'd0);
      check_val("s6_late_busy", 32'(ch_busy), 32'h0);
      check_val("s6_late_audio", 32'(audio_out), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
